layer_flatten: RTL and testbench

//  Downstream stage of the convolution/max-pool engine. Reads the two 32x32 max-pooled maps
//  (layer-1, csel 3 = kernel0, csel 4 = kernel1) and writes them channel-interleaved into the

---
 rtl/layer_flatten.sv | 146 ++++++++++++++
 tb/tb_layer_flatten.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer_flatten.sv
// rtl/layer_flatten.sv - channel-interleaving flatten stage for pooled layer-1 maps
//
// Reads NUM_CH pooled maps of MAP_SZ words each (channel ch lives at csel CSEL_L1+ch)
// and writes them interleaved into the flattened memory at csel CSEL_L2:
//   L2[idx*NUM_CH + ch] = L1_ch[idx]
// Each word takes one RD cycle followed by one WR cycle on the shared layer-memory bus.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     one-cycle run request, honoured only in IDLE
//   busy      high from the first RD until DONE is left
//   done      one-cycle pulse after the last write
//   crd       read strobe;  caddr_rd read address;  cdata_rd zero-wait read data
//   cwr       write strobe; caddr_wr write address; cdata_wr write data
//   csel      memory select for the current access (0 when idle)

module layer_flatten #(
  parameter int DW      = 20,
  parameter int AW      = 12,
  parameter int MAP_SZ  = 1024,
  parameter int NUM_CH  = 2,
  parameter int CSEL_L1 = 3,
  parameter int CSEL_L2 = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  localparam int IW = (MAP_SZ > 1) ? $clog2(MAP_SZ) : 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // The flattened image must fit in the address space.
  if (MAP_SZ * NUM_CH > 2 ** AW) begin : g_addr_check
    $error("layer_flatten: MAP_SZ*NUM_CH exceeds 2**AW");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   ch;
  logic [DW-1:0]   data_q;

  logic            idx_last;
  logic            ch_last;

  assign idx_last = (idx == IW'(MAP_SZ - 1));
  assign ch_last  = (ch  == CW'(NUM_CH - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and output decode; outputs depend only on registered state,
  // counters and the captured word, never on inputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    crd      = 1'b0;
    cwr      = 1'b0;
    caddr_rd = '0;
    caddr_wr = '0;
    cdata_wr = '0;
    csel     = '0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_RD;
        end
      end
      S_RD: begin
        busy     = 1'b1;
        crd      = 1'b1;
        csel     = 3'(CSEL_L1) + 3'(ch);
        caddr_rd = AW'(idx);
        state_nx = S_WR;
      end
      S_WR: begin
        busy     = 1'b1;
        cwr      = 1'b1;
        csel     = 3'(CSEL_L2);
        caddr_wr = AW'(idx) * AW'(NUM_CH) + AW'(ch);
        cdata_wr = data_q;
        state_nx = (idx_last && ch_last) ? S_DONE : S_RD;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Walk channel fastest, then word index; both wrap to zero after the final
  // write so the block is ready for the next run by the time DONE is reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
      ch  <= '0;
    end else if (state == S_WR) begin
      if (ch_last) begin
        ch  <= '0;
        idx <= idx_last ? '0 : idx + 1'b1;
      end else begin
        ch  <= ch + 1'b1;
      end
    end
  end

  // Zero-wait memory: read data is valid during RD and is held for the WR cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else if (state == S_RD) begin
      data_q <= cdata_rd;
    end
  end

endmodule

// File: tb/tb_layer_flatten.sv
// tb/tb_layer_flatten.sv - randomized self-checking bench for layer_flatten

module tb_layer_flatten;

  localparam int DW     = 20;
  localparam int AW     = 12;
  localparam int MAP_SZ = 1024;
  localparam int NUM_CH = 2;
  localparam int TOTAL  = MAP_SZ * NUM_CH;
  localparam int BOUND  = 6000;

  logic          clk;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  layer_flatten dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] l1_0 [MAP_SZ];
  logic [DW-1:0] l1_1 [MAP_SZ];
  logic [DW-1:0] l2   [TOTAL];

  // Zero-wait layer memory read port
  always_comb begin
    cdata_rd = '0;
    if (csel == 3'd3)      cdata_rd = l1_0[caddr_rd[9:0]];
    else if (csel == 3'd4) cdata_rd = l1_1[caddr_rd[9:0]];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Bus protocol monitor, sampled every falling edge
  int bus_viol = 0;
  always @(negedge clk) begin
    if (crd && cwr) bus_viol++;
    if (crd != (csel == 3'd3 || csel == 3'd4)) bus_viol++;
    if (cwr != (csel == 3'd5)) bus_viol++;
    if (!crd && caddr_rd != '0) bus_viol++;
    if (!cwr && caddr_wr != '0) bus_viol++;
  end

  // Results of the most recent run
  int r_first_rd, r_done, r_wr_count, r_first_wr_addr, r_busy_bad, r_start_rd_addr;
  logic r_done_seen, r_done_len_ok, r_idle_ok;

  // Called at (or just after) a falling edge; start is raised now and
  // sampled by the DUT at the next rising edge.
  task automatic do_run(input int pulse_idx);
    int cyc;
    for (int i = 0; i < TOTAL; i++) l2[i] = 'x;
    r_first_rd = -1; r_done = -1; r_wr_count = 0; r_first_wr_addr = -1;
    r_busy_bad = 0; r_done_seen = 1'b0; r_done_len_ok = 1'b0; r_idle_ok = 1'b0;
    r_start_rd_addr = -1;
    cyc = 0;
    start = 1'b1;
    while (cyc < BOUND && !r_done_seen) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (crd && r_first_rd < 0) begin
        r_first_rd = cyc;
        r_start_rd_addr = {csel, 1'b0, caddr_rd};
      end
      if (r_first_rd >= 0 && !busy) r_busy_bad++;
      if (cwr) begin
        if (r_first_wr_addr < 0) r_first_wr_addr = int'(caddr_wr);
        if (int'(caddr_wr) < TOTAL) l2[caddr_wr] = cdata_wr;
        r_wr_count++;
      end
      if (pulse_idx >= 0 && crd && int'(caddr_rd) == pulse_idx && csel == 3'd3) start = 1'b1;
      if (done) begin
        r_done = cyc;
        r_done_seen = 1'b1;
      end
    end
    if (r_done_seen) begin
      @(negedge clk);
      r_done_len_ok = !done;
      r_idle_ok = !busy && !crd && !cwr;
    end
  endtask

  // Reference: L2[NUM_CH*i + ch] = L1_ch[i]; timing two cycles per word.
  task automatic check_run(input string name);
    int bad;
    bad = 0;
    check({name, "_done_seen"}, 32'(r_done_seen), 32'd1);
    check({name, "_first_rd_cycle"}, 32'(r_first_rd), 32'd1);
    check({name, "_first_rd_addr"}, 32'(r_start_rd_addr), {16'd0, 3'd3, 1'b0, 12'd0});
    check({name, "_done_offset"}, 32'(r_done - r_first_rd), 32'(2 * TOTAL));
    check({name, "_wr_count"}, 32'(r_wr_count), 32'(TOTAL));
    check({name, "_first_wr_addr"}, 32'(r_first_wr_addr), 32'd0);
    check({name, "_busy_during_run"}, 32'(r_busy_bad), 32'd0);
    check({name, "_done_one_cycle"}, 32'(r_done_len_ok), 32'd1);
    check({name, "_idle_after_done"}, 32'(r_idle_ok), 32'd1);
    for (int i = 0; i < MAP_SZ; i++) begin
      if (l2[NUM_CH * i]     !== l1_0[i]) bad++;
      if (l2[NUM_CH * i + 1] !== l1_1[i]) bad++;
    end
    check({name, "_l2_mismatches"}, 32'(bad), 32'd0);
    check({name, "_l2_first"}, 32'(l2[0]), 32'(l1_0[0]));
    check({name, "_l2_last"}, 32'(l2[TOTAL - 1]), 32'(l1_1[MAP_SZ - 1]));
  endtask

  task automatic randomize_maps();
    for (int i = 0; i < MAP_SZ; i++) begin
      l1_0[i] = DW'($urandom);
      l1_1[i] = DW'($urandom);
    end
    l1_0[0] = 20'h80001;
    l1_1[MAP_SZ - 1] = 20'hFFFFF;
  endtask

  int first_done_cycle;
  int cnt_wr;
  int cnt_busy;
  int guard;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < MAP_SZ; i++) begin
      l1_0[i] = DW'(i);
      l1_1[i] = 20'h80000 | DW'(i);
    end
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_crd", 32'(crd), 32'd0);
    check("rst_cwr", 32'(cwr), 32'd0);
    check("rst_csel", 32'(csel), 32'd0);
    check("rst_caddr_rd", 32'(caddr_rd), 32'd0);
    check("rst_caddr_wr", 32'(caddr_wr), 32'd0);
    check("rst_cdata_wr", 32'(cdata_wr), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Full run with ramp patterns
    do_run(-1);
    check_run("ramp");
    first_done_cycle = r_done;

    // Random data, stray start while busy
    randomize_maps();
    repeat (3) @(negedge clk);
    do_run(10);
    check_run("stray_start");
    check("stray_start_same_end", 32'(r_done), 32'(first_done_cycle));
    repeat (4) @(negedge clk);
    check("stray_start_not_queued", 32'(busy), 32'd0);

    // Back-to-back runs, second started in the cycle after done
    randomize_maps();
    @(negedge clk);
    do_run(-1);
    check_run("b2b_a");
    randomize_maps();
    do_run(-1);
    check_run("b2b_b");
    check("b2b_same_timing", 32'(r_done), 32'(first_done_cycle));

    // Reset mid-run at idx=500
    randomize_maps();
    @(negedge clk);
    start = 1'b1;
    guard = 0;
    @(negedge clk);
    start = 1'b0;
    while (!(crd && caddr_rd == 12'd500 && csel == 3'd3) && guard < BOUND) begin
      @(negedge clk);
      guard++;
    end
    check("midrst_reached_idx500", 32'(guard < BOUND), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_crd", 32'(crd), 32'd0);
    check("midrst_cwr", 32'(cwr), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_csel", 32'(csel), 32'd0);
    check("midrst_caddr_rd", 32'(caddr_rd), 32'd0);
    check("midrst_cdata_wr", 32'(cdata_wr), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cnt_wr = 0;
    cnt_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cwr) cnt_wr++;
      if (busy) cnt_busy++;
    end
    check("midrst_no_writes_after", 32'(cnt_wr), 32'd0);
    check("midrst_stays_idle", 32'(cnt_busy), 32'd0);

    // Restart after reset begins again from word 0
    do_run(-1);
    check_run("after_rst");

    check("bus_protocol_violations", 32'(bus_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
